// File: rtl/serial_in_if.sv
// Consumer-side bundle of the UART receiver: FIFO head byte with valid/ready, plus error pulses.
// master = receiver (drives data and pulses), slave = consumer (drives ready).
`timescale 1ns/1ps
interface serial_in_if;
    logic [7:0] char;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    modport master (output char, output valid, output frame_err, output overrun, input ready);
    modport slave  (input char, input valid, input frame_err, input overrun, output ready);
endinterface

// File: rtl/serial_in.sv
// UART receiver (8N1, or 8E1 when SERIAL_IN_PARITY_EN is defined) feeding a first-word-fall-through FIFO.
// Latency: valid rises one clock after the stop-bit mid sample on an empty FIFO.
// Backpressure: ready pops the head; a byte completing into a full FIFO without a pop is dropped with overrun.
`timescale 1ns/1ps
module serial_in #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUDRATE   = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          uart_rx,
    serial_in_if.master   rx_if
);
    localparam int BIT_CLKS = CLK_FREQ / BAUDRATE;
    localparam int CNT_W    = $clog2(BIT_CLKS + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_IN_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
`ifdef SERIAL_IN_PARITY_EN
    logic             par_ok_q, par_ok_d;
`endif

    logic push_req;
    logic frame_ok;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_ok;

    // Receiver: counter restarts on every state change, each bit is sampled when it expires.
    always_comb begin
        rx_meta_d   = uart_rx;
        rx_sync_d   = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
`ifdef SERIAL_IN_PARITY_EN
        par_ok_d    = par_ok_q;
        frame_ok    = rx_sync_q && par_ok_q;
`else
        frame_ok    = rx_sync_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_IN_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_IN_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    par_ok_d = (rx_sync_q == ^shift_q);
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid stop bit so a start bit right after it is not missed.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (frame_ok) push_req    = 1'b1;
                    else          frame_err_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FIFO: extra pointer bit separates full from empty; a pop frees the slot for a same-cycle push.
    always_comb begin
        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop        = !fifo_empty && rx_if.ready;
        push_ok    = push_req && (!fifo_full || pop);
        overrun_d  = push_req && fifo_full && !pop;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mem_d      = mem_q;
        if (push_ok) begin
            mem_d[wptr_q[AW-1:0]] = shift_q;
            wptr_d                = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef SERIAL_IN_PARITY_EN
            par_ok_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_q       <= mem_d;
`ifdef SERIAL_IN_PARITY_EN
            par_ok_q    <= par_ok_d;
`endif
        end
    end

    assign rx_if.valid     = !fifo_empty;
    assign rx_if.char      = fifo_empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
endmodule
